// File: rtl/s27_frame_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// s27_frame_ctrl: owns the s27 state register and steps the core frame by frame
// Rev 1.0
// ----------------------------------------------------------------------------
module s27_frame_ctrl #(
  parameter int NFRAMES_W = 8,
  parameter int TRACE_W   = 16
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [2:0]           INIT_STATE,
  input  logic [NFRAMES_W-1:0] NUM_FRAMES,
  input  logic                 VEC_VALID,
  input  logic [3:0]           VEC_DATA,
  output logic                 VEC_READY,
  output logic [3:0]           CORE_G,
  output logic [2:0]           CORE_Q,
  input  logic [2:0]           CORE_D,
  input  logic                 CORE_G17,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [2:0]           FINAL_STATE,
  output logic [NFRAMES_W-1:0] FRAME_CNT,
  output logic [TRACE_W-1:0]   TRACE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EVAL   = 2'd2,
    FINISH = 2'd3
  } fsm_t;

  fsm_t                 state;
  fsm_t                 state_nxt;
  logic [2:0]           state_reg;
  logic [3:0]           g_reg;
  logic [NFRAMES_W-1:0] num_reg;
  logic [NFRAMES_W-1:0] frame_cnt;
  logic [NFRAMES_W-1:0] frame_inc;
  logic [TRACE_W-1:0]   trace;
  logic                 vec_fire;

  assign frame_inc = frame_cnt + {{(NFRAMES_W-1){1'b0}}, 1'b1};
  assign vec_fire  = VEC_VALID && VEC_READY;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ABORT masks VEC_READY so an aborted cycle never consumes a vector.
  always_comb begin
    state_nxt = state;
    VEC_READY = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          state_nxt = (NUM_FRAMES == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        BUSY      = 1'b1;
        VEC_READY = !ABORT;
        if (ABORT) begin
          state_nxt = IDLE;
        end else if (VEC_VALID) begin
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        BUSY = 1'b1;
        if (ABORT) begin
          state_nxt = IDLE;
        end else if (frame_inc == num_reg) begin
          state_nxt = FINISH;
        end else begin
          state_nxt = RUN;
        end
      end
      FINISH: begin
        BUSY      = 1'b1;
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_reg <= 3'b000;
      g_reg     <= 4'b0000;
      num_reg   <= '0;
      frame_cnt <= '0;
      trace     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            num_reg   <= NUM_FRAMES;
            state_reg <= INIT_STATE;
            frame_cnt <= '0;
            trace     <= '0;
          end
        end
        RUN: begin
          if (vec_fire) begin
            g_reg <= VEC_DATA;
          end
        end
        EVAL: begin
          // The core has had a full cycle to settle on g_reg/state_reg.
          if (!ABORT) begin
            state_reg <= CORE_D;
            trace     <= {trace[TRACE_W-2:0], CORE_G17};
            frame_cnt <= frame_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign CORE_G      = g_reg;
  assign CORE_Q      = state_reg;
  assign FINAL_STATE = state_reg;
  assign FRAME_CNT   = frame_cnt;
  assign TRACE       = trace;

endmodule
`default_nettype wire

// File: doc/s27_frame_ctrl.md
Name: s27_frame_ctrl

Overview:
- Sequencing controller for the s27 combinational core, whose state flops are cut out as DFF_x_Q / DFF_x_D pins.
- Owns the 3-bit state register and walks the core through a programmed number of time frames.
- Takes one input vector per frame over a valid/ready handshake and records the G17 output per frame in a shift trace.
- Sits between a test/stimulus source and the core; the core itself stays purely combinational.

Parameters:
NFRAMES_W, 8, width of frame-count request and counter
TRACE_W, 16, width of G17 trace shift register (>=2)

Ports:
CK  input  1  clock, rising edge
RN  input  1  asynchronous active-low reset
START  input  1  job start pulse; sampled only in IDLE
ABORT  input  1  cancel running job; sampled in RUN/EVAL
INIT_STATE  input  3  initial {DFF_2,DFF_1,DFF_0} state, latched on START
NUM_FRAMES  input  NFRAMES_W  frames to run, latched on START
VEC_VALID  input  1  input vector valid
VEC_DATA  input  4  {G3,G2,G1,G0} for one frame
VEC_READY  output  1  controller accepts a vector this cycle
CORE_G  output  4  {G3,G2,G1,G0} to core
CORE_Q  output  3  {DFF_2_Q,DFF_1_Q,DFF_0_Q} to core
CORE_D  input  3  {DFF_2_D,DFF_1_D,DFF_0_D} from core
CORE_G17  input  1  G17 from core
BUSY  output  1  high in RUN/EVAL/FINISH
DONE  output  1  one-cycle completion pulse
FINAL_STATE  output  3  state register value, valid when DONE
FRAME_CNT  output  NFRAMES_W  frames completed in current/last job
TRACE  output  TRACE_W  G17 history, newest in bit 0

Behaviour:
- One clock (CK). Asynchronous active-low reset (RN).
- Reset: FSM=IDLE; state_reg, g_reg, FRAME_CNT, TRACE, num_reg = 0; VEC_READY=0, BUSY=0, DONE=0. CORE_Q=0, CORE_G=0.
- CORE_Q is always state_reg. CORE_G is always g_reg. Both are registered; no combinational path from VEC_DATA to the core.
- FINAL_STATE is always state_reg.

FSM states: IDLE, RUN, EVAL, FINISH.
- IDLE, START=1:
  - Latch num_reg<=NUM_FRAMES, state_reg<=INIT_STATE; clear FRAME_CNT and TRACE.
  - Next state: FINISH if NUM_FRAMES==0, else RUN.
- IDLE, START=0: hold all registers.
- RUN:
  - VEC_READY=1.
  - On VEC_VALID&VEC_READY: g_reg<=VEC_DATA, go to EVAL.
  - Otherwise stay; stalls of any length are allowed.
- EVAL:
  - VEC_READY=0. Core settles on registered CORE_G/CORE_Q.
  - Capture state_reg<=CORE_D, TRACE<={TRACE[TRACE_W-2:0],CORE_G17}, FRAME_CNT<=FRAME_CNT+1.
  - Next state: FINISH if FRAME_CNT+1==num_reg, else RUN.
- FINISH: DONE=1 for exactly this cycle, then IDLE. Throughput is one frame per 2 cycles.
- ABORT:
  - ABORT=1 in RUN or EVAL → IDLE next cycle. No DONE, no capture in that EVAL.
  - state_reg, FRAME_CNT and TRACE keep their pre-abort values.
  - ABORT has priority over a same-cycle handshake; the vector is not consumed (VEC_READY is forced 0 when ABORT=1).
- START while BUSY is ignored. START and ABORT together in IDLE: START wins.
- FRAME_CNT wraps modulo 2^NFRAMES_W, but it cannot exceed num_reg.
- TRACE keeps the last TRACE_W frames; older bits shift out.
- RN asserted mid-job: immediate return to reset values; the job is lost.

Test Plan:
- Reset: hold RN=0 with START=1, VEC_VALID=1 → all outputs 0, VEC_READY=0; after release, IDLE with BUSY=0.
- Two-frame job, real s27 core attached:
  - Stimulus: INIT_STATE=000, NUM_FRAMES=2, START at cycle 0, VEC_VALID held with 0000 then 1001.
  - Required: vectors accepted at cycles 1 and 3. After frame 1, state=000 and G17=1; after frame 2, state=010 and G17=0.
  - Required: DONE at cycle 5, FINAL_STATE=010, TRACE=0x0002, FRAME_CNT=2.
- Backpressure: as in the two-frame job, but with VEC_VALID low for 3 cycles before each vector → FSM stays in RUN with VEC_READY=1; same final results; DONE at cycle 11.
- Zero frames: NUM_FRAMES=0, INIT_STATE=101 → DONE on the cycle after START, FINAL_STATE=101, FRAME_CNT=0, TRACE=0, VEC_READY never high.
- Abort: NUM_FRAMES=5; assert ABORT in RUN after 2 frames with VEC_VALID=1 → no handshake, IDLE next cycle, no DONE, FRAME_CNT=2, state after frame 2 retained. A following START runs normally.
- Trace/START-while-busy:
  - 20 frames of vector 0000 from state 000 → TRACE=0xFFFF, FRAME_CNT=20.
  - A START pulsed mid-job does not change num_reg or state_reg.
